// File: rtl/bp_btb.sv
// ---------------------------------------------------------------------------
// bp_btb -- direct-mapped branch target buffer with per-entry saturating
// direction counters and two saturating performance counters.
//
// IF side:  if_pc is looked up combinationally in the registered table and
//           produces pred_taken / pred_target (target forced to 0 when not
//           predicting taken).
// EX side:  the resolved outcome of a control-transfer instruction updates
//           the indexed entry on the rising edge, and ex_mispredict tells the
//           pipeline whether the prediction carried down from IF was wrong.
//
// Ports:
//   cpu_clk, cpu_rst_n          clock, asynchronous active-low reset
//   if_pc                       fetch PC to predict
//   pred_taken, pred_target     IF prediction
//   ex_valid, ex_is_branch,
//   ex_is_jump, ex_pc,
//   ex_taken, ex_target         resolved EX instruction
//   ex_pred_taken,
//   ex_pred_target              prediction made for it in IF
//   ex_mispredict               redirect / flush required
//   flush_all                   invalidate every entry at the next edge
//   stat_ctrl, stat_miss        resolved control ops / mispredicts
// ---------------------------------------------------------------------------
module bp_btb #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              ex_mispredict,
    input  logic              flush_all,
    output logic [STAT_W-1:0] stat_ctrl,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Only the MSB set: the weakly-taken state a new branch starts in.
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_MAX ^ (CNT_MAX >> 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    // Table storage
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    logic [STAT_W-1:0] stat_ctrl_q;
    logic [STAT_W-1:0] stat_miss_q;

    // Lookup (IF)
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign pred_taken  = if_hit & cnt_q[if_idx][CNT_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : '0;

    // Resolution (EX)
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             taken_eff;
    logic             ctrl;

    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = ex_pc[ADDR_W-1:IDX_W+2];
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign taken_eff = ex_is_jump | ex_taken;
    assign ctrl      = ex_valid & (ex_is_branch | ex_is_jump);

    // A not-taken outcome has no meaningful target, so only the direction
    // is compared in that case.
    assign ex_mispredict = ctrl &
                           ((ex_pred_taken != taken_eff) |
                            (taken_eff & (ex_pred_target != ex_target)));

    // Next value for the indexed entry. Jumps take precedence over the
    // branch flag, so a malformed both-set encoding behaves as a jump.
    logic              upd_we;
    logic [ADDR_W-1:0] upd_target_d;
    logic [CNT_W-1:0]  upd_cnt_d;

    always_comb begin
        upd_we       = 1'b0;
        upd_target_d = target_q[ex_idx];
        upd_cnt_d    = cnt_q[ex_idx];
        if (ctrl) begin
            if (ex_hit) begin
                upd_we = 1'b1;
                if (ex_is_jump) begin
                    upd_cnt_d    = CNT_MAX;
                    upd_target_d = ex_target;
                end else if (ex_taken) begin
                    if (cnt_q[ex_idx] != CNT_MAX) begin
                        upd_cnt_d = cnt_q[ex_idx] + CNT_W'(1);
                    end
                    upd_target_d = ex_target;
                end else begin
                    if (cnt_q[ex_idx] != '0) begin
                        upd_cnt_d = cnt_q[ex_idx] - CNT_W'(1);
                    end
                end
            end else if (taken_eff) begin
                // Allocation simply evicts whatever occupied the slot.
                upd_we       = 1'b1;
                upd_target_d = ex_target;
                upd_cnt_d    = ex_is_jump ? CNT_MAX : CNT_WEAK;
            end
        end
    end

    // Table update; flush wins over a simultaneous update.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_we) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= upd_target_d;
            cnt_q[ex_idx]    <= upd_cnt_d;
        end
    end

    // Performance counters: saturate, unaffected by flush_all.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            stat_ctrl_q <= '0;
            stat_miss_q <= '0;
        end else begin
            if (ctrl && stat_ctrl_q != STAT_MAX) begin
                stat_ctrl_q <= stat_ctrl_q + STAT_W'(1);
            end
            if (ex_mispredict && stat_miss_q != STAT_MAX) begin
                stat_miss_q <= stat_miss_q + STAT_W'(1);
            end
        end
    end

    assign stat_ctrl = stat_ctrl_q;
    assign stat_miss = stat_miss_q;

    // PCs are word aligned; the low bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

endmodule

// File: tb/tb_bp_btb.sv
// ---------------------------------------------------------------------------
// tb_bp_btb -- self-checking bench for bp_btb (ENTRIES=64, ADDR_W=32,
// CNT_W=2, STAT_W=4 so the performance counters saturate quickly).
// A vector table drives one cycle per record; each record's expected
// outputs go into a scoreboard queue and are compared at the falling edge.
// ---------------------------------------------------------------------------
module tb_bp_btb;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;
    logic        flush_all;
    logic [3:0]  stat_ctrl;
    logic [3:0]  stat_miss;

    int checks = 0;
    int errors = 0;

    bp_btb #(
        .ENTRIES(64),
        .ADDR_W (32),
        .CNT_W  (2),
        .STAT_W (4)
    ) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst_n     (cpu_rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .ex_mispredict (ex_mispredict),
        .flush_all     (flush_all),
        .stat_ctrl     (stat_ctrl),
        .stat_miss     (stat_miss)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] ifPc;
        logic        valid;
        logic        br;
        logic        jmp;
        logic [31:0] exPc;
        logic        taken;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        flush;
        logic        ePt;
        logic [31:0] eTgt;
        logic        eMis;
        int          eCtrl;
        int          eMiss;
    } vec_t;

    typedef struct {
        int          id;
        logic        ePt;
        logic [31:0] eTgt;
        logic        eMis;
        int          eCtrl;
        int          eMiss;
    } exp_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];
    exp_t sbQ[$];

    function automatic vec_t mk(
        input logic [31:0] ifPc, input logic v, input logic br, input logic jmp,
        input logic [31:0] exPc, input logic tk, input logic [31:0] tgt,
        input logic pt, input logic [31:0] ptgt, input logic fl,
        input logic ePt, input logic [31:0] eTgt, input logic eMis,
        input int eCtrl, input int eMiss);
        vec_t r;
        r.ifPc = ifPc; r.valid = v; r.br = br; r.jmp = jmp; r.exPc = exPc;
        r.taken = tk; r.tgt = tgt; r.pt = pt; r.ptgt = ptgt; r.flush = fl;
        r.ePt = ePt; r.eTgt = eTgt; r.eMis = eMis;
        r.eCtrl = eCtrl; r.eMiss = eMiss;
        return r;
    endfunction

    // Single comparison primitive shared by scoreboard and direct checks.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge and queue the
    // outputs expected before the next rising edge.
    task automatic applyStimulus(input vec_t v, input int id);
        @(posedge cpu_clk);
        #1;
        if_pc          = v.ifPc;
        ex_valid       = v.valid;
        ex_is_branch   = v.br;
        ex_is_jump     = v.jmp;
        ex_pc          = v.exPc;
        ex_taken       = v.taken;
        ex_target      = v.tgt;
        ex_pred_taken  = v.pt;
        ex_pred_target = v.ptgt;
        flush_all      = v.flush;
        sbQ.push_back('{id, v.ePt, v.eTgt, v.eMis, v.eCtrl, v.eMiss});
    endtask

    // Monitor: compare the oldest queued expectation at the falling edge.
    always @(negedge cpu_clk) begin
        if (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput($sformatf("v%0d pred_taken", e.id), 32'(pred_taken), 32'(e.ePt));
            checkOutput($sformatf("v%0d pred_target", e.id), pred_target, e.eTgt);
            checkOutput($sformatf("v%0d mispredict", e.id), 32'(ex_mispredict), 32'(e.eMis));
            checkOutput($sformatf("v%0d stat_ctrl", e.id), 32'(stat_ctrl), 32'(e.eCtrl));
            checkOutput($sformatf("v%0d stat_miss", e.id), 32'(stat_miss), 32'(e.eMiss));
        end
    end

    task automatic idleInputs();
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pc = 0;
        ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        flush_all = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int modelCtrl;
        int modelMiss;
        vec_t v;

        // Indices 0x100, 0x200, 0x300 all map to entry 0 with distinct tags.
        //            ifPc   v  br jmp exPc   tk tgt    pt ptgt   fl ePt eTgt  eMis ctrl miss
        vecs[0]  = mk('h100, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0,  0,  0);
        vecs[1]  = mk('h100, 1, 1, 0, 'h100, 1, 'h80,  0, 'h0,   0, 0, 'h0,  1,  0,  0);
        vecs[2]  = mk('h100, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 1, 'h80, 0,  1,  1);
        vecs[3]  = mk('h100, 1, 1, 0, 'h100, 1, 'h80,  1, 'h80,  0, 1, 'h80, 0,  1,  1);
        vecs[4]  = mk('h100, 1, 1, 0, 'h100, 1, 'h80,  1, 'h80,  0, 1, 'h80, 0,  2,  1);
        vecs[5]  = mk('h100, 1, 1, 0, 'h100, 1, 'h80,  1, 'h80,  0, 1, 'h80, 0,  3,  1);
        vecs[6]  = mk('h100, 1, 1, 0, 'h100, 0, 'h80,  1, 'h80,  0, 1, 'h80, 1,  4,  1);
        vecs[7]  = mk('h100, 1, 1, 0, 'h100, 0, 'h80,  1, 'h80,  0, 1, 'h80, 1,  5,  2);
        vecs[8]  = mk('h100, 1, 1, 0, 'h100, 0, 'h80,  0, 'h0,   0, 0, 'h0,  0,  6,  3);
        vecs[9]  = mk('h100, 1, 1, 0, 'h100, 0, 'h80,  0, 'h0,   0, 0, 'h0,  0,  7,  3);
        vecs[10] = mk('h100, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0,  8,  3);
        vecs[11] = mk('h100, 1, 1, 0, 'h100, 1, 'h80,  0, 'h0,   0, 0, 'h0,  1,  8,  3);
        vecs[12] = mk('h100, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0,  9,  4);
        vecs[13] = mk('h100, 1, 1, 0, 'h100, 1, 'h80,  0, 'h0,   0, 0, 'h0,  1,  9,  4);
        vecs[14] = mk('h100, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 1, 'h80, 0, 10,  5);
        vecs[15] = mk('h200, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0, 10,  5);
        vecs[16] = mk('h200, 1, 0, 1, 'h200, 0, 'h40,  0, 'h0,   0, 0, 'h0,  1, 10,  5);
        vecs[17] = mk('h200, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 1, 'h40, 0, 11,  6);
        vecs[18] = mk('h100, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0, 11,  6);
        vecs[19] = mk('h200, 1, 0, 1, 'h200, 0, 'h60,  1, 'h40,  0, 1, 'h40, 1, 11,  6);
        vecs[20] = mk('h200, 1, 0, 1, 'h200, 0, 'h60,  1, 'h60,  0, 1, 'h60, 0, 12,  7);
        vecs[21] = mk('h200, 1, 0, 0, 'h200, 1, 'h999, 1, 'h999, 0, 1, 'h60, 0, 13,  7);
        vecs[22] = mk('h200, 0, 1, 0, 'h300, 1, 'h123, 0, 'h0,   0, 1, 'h60, 0, 13,  7);
        vecs[23] = mk('h300, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0, 13,  7);
        vecs[24] = mk('h200, 1, 1, 0, 'h300, 1, 'h44,  0, 'h0,   1, 1, 'h60, 1, 13,  7);
        vecs[25] = mk('h200, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0, 14,  8);
        vecs[26] = mk('h300, 0, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h0,  0, 14,  8);

        // Reset state while reset is held
        cpu_rst_n = 1'b0;
        if_pc = 'h100;
        idleInputs();
        #3;
        $display("[TB] checking reset state");
        checkOutput("reset pred_taken", 32'(pred_taken), 32'd0);
        checkOutput("reset pred_target", pred_target, 32'd0);
        checkOutput("reset stat_ctrl", 32'(stat_ctrl), 32'd0);
        checkOutput("reset stat_miss", 32'(stat_miss), 32'd0);
        @(posedge cpu_clk);
        #2;
        cpu_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Counter saturation: 10 mispredicting taken branches at 0x500
        // while fetch looks at an empty entry.
        modelCtrl = 14;
        modelMiss = 8;
        for (int k = 0; k < 10; k++) begin
            v = mk('h104, 1, 1, 0, 'h500, 1, 'h520, 0, 'h0, 0,
                   0, 'h0, 1, modelCtrl, modelMiss);
            applyStimulus(v, 100 + k);
            if (modelCtrl < 15) modelCtrl++;
            if (modelMiss < 15) modelMiss++;
        end
        v = mk('h500, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 0,
               1, 'h520, 0, modelCtrl, modelMiss);
        applyStimulus(v, 110);
        @(negedge cpu_clk);
        #1;

        // Asynchronous reset pulse between edges with a control op in EX
        @(posedge cpu_clk);
        #2;
        ex_valid = 1; ex_is_branch = 1; ex_pc = 'h700; ex_taken = 1;
        ex_target = 'h720; ex_pred_taken = 0;
        cpu_rst_n = 1'b0;
        #1;
        checkOutput("async pred_taken", 32'(pred_taken), 32'd0);
        checkOutput("async pred_target", pred_target, 32'd0);
        checkOutput("async stat_ctrl", 32'(stat_ctrl), 32'd0);
        checkOutput("async stat_miss", 32'(stat_miss), 32'd0);
        checkOutput("async mispredict", 32'(ex_mispredict), 32'd1);
        idleInputs();
        #1;
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk);
        #1;
        checkOutput("post-reset pred_taken", 32'(pred_taken), 32'd0);
        checkOutput("post-reset stat_ctrl", 32'(stat_ctrl), 32'd0);

        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
